aes: RTL and testbench

AES -- requirements
Module: aes

---
 rtl/aes.sv | 234 +++++++++++++++++++++++
 tb/tb_aes.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/aes.sv
// AES-128 encryption core, iterative: one full round per clock edge.
// Plaintext and key are loaded one 32-bit word per edge, MSW first.
// The ciphertext is read back as four words on request.
// Optional build macro AES_ZEROIZE_EN: when defined, the state and key
// registers are cleared after a readout and the FSM drops back to IDLE.
module aes (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_n,
  input  logic        start_read_n,
  input  logic [31:0] dword_in,
  output logic [31:0] dword_out,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    DONE  = 3'd3,
    READ  = 3'd4
  } fsm_e;

  // Forward S-box, FIPS-197 Figure 7.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte b (row r, column c, b = r + 4c) lives at bits [127-8b -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        // ShiftRows: row r rotates left by r columns.
        o[127 - 8*(r + 4*c) -: 8] = SBOX[s[127 - 8*(r + 4*((c + r) % 4)) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One step of the key schedule: previous round key -> next round key.
  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] sel_word(input logic [127:0] s, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = s[127:96];
      2'd1:    w = s[95:64];
      2'd2:    w = s[63:32];
      default: w = s[31:0];
    endcase
    return w;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  dword_q, dword_d;
  logic         done_q, done_d;

  logic [127:0] next_key;
  logic [127:0] shifted;
  logic [127:0] round_out;

  // Datapath for one encryption round; cnt_q holds the round number in ROUND.
  always_comb begin
    next_key  = expand_key(key_q, rcon(cnt_q));
    shifted   = sub_shift(state_q);
    round_out = ((cnt_q == 4'd10) ? shifted : mix_columns(shifted)) ^ next_key;
  end

  // Next-state and register-update logic for the control FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    dword_d = '0;
    done_d  = done_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (!start_n) begin
          state_d = {dword_in, 96'h0};
          cnt_d   = 4'd1;
          done_d  = 1'b0;
          fsm_d   = LOAD;
        end else if (fsm_q == DONE && !start_read_n) begin
          dword_d = state_q[127:96];
          cnt_d   = 4'd1;
          fsm_d   = READ;
        end
      end
      LOAD: begin
        cnt_d = cnt_q + 4'd1;
        case (cnt_q)
          4'd1: state_d[95:64]  = dword_in;
          4'd2: state_d[63:32]  = dword_in;
          4'd3: state_d[31:0]   = dword_in;
          4'd4: key_d[127:96]   = dword_in;
          4'd5: key_d[95:64]    = dword_in;
          4'd6: key_d[63:32]    = dword_in;
          4'd7: key_d[31:0]     = dword_in;
          default: begin
            // Initial AddRoundKey, then round 1 on the next edge.
            state_d = state_q ^ key_q;
            cnt_d   = 4'd1;
            fsm_d   = ROUND;
          end
        endcase
      end
      ROUND: begin
        state_d = round_out;
        key_d   = next_key;
        if (cnt_q == 4'd10) begin
          cnt_d  = 4'd0;
          done_d = 1'b1;
          fsm_d  = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      READ: begin
        if (cnt_q == 4'd4) begin
          cnt_d = 4'd0;
          fsm_d = DONE;
`ifdef AES_ZEROIZE_EN
          state_d = '0;
          key_d   = '0;
          done_d  = 1'b0;
          fsm_d   = IDLE;
`endif
        end else begin
          dword_d = sel_word(state_q, cnt_q[1:0]);
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State, key, counter and output registers; reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the wide state/key registers are reset too, so an aborted run leaves no residue.
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      dword_q <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      dword_q <= dword_d;
      done_q  <= done_d;
    end
  end

  assign dword_out = dword_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes.sv
// Directed bench for the aes core: known-answer vectors plus readout,
// priority and reset corner sequences. Inputs change and outputs are
// sampled on the falling edge of clk.
module tb_aes;

  logic        clk;
  logic        reset_n;
  logic        start_n;
  logic        start_read_n;
  logic [31:0] dword_in;
  logic [31:0] dword_out;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  aes dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_n      (start_n),
    .start_read_n (start_read_n),
    .dword_in     (dword_in),
    .dword_out    (dword_out),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; leaves just after the falling edge following C7.
  task automatic do_load(input logic [127:0] pt, input logic [127:0] key, input logic rd_too);
    start_n      = 1'b0;
    start_read_n = rd_too ? 1'b0 : 1'b1;
    dword_in     = pt[127:96];
    @(negedge clk);
    check("c0_done_clear", {127'h0, done}, 128'h0);
    check("c0_dword_zero", {96'h0, dword_out}, 128'h0);
    start_n      = 1'b1;
    start_read_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      if (i < 4) dword_in = pt[127 - 32*i -: 32];
      else       dword_in = key[127 - 32*(i - 4) -: 32];
      @(negedge clk);
    end
    dword_in = '0;
  endtask

  // Edges C8..C17 must leave done low; done rises after C18.
  task automatic run_wait();
    repeat (10) @(negedge clk);
    check("done_before_c18", {127'h0, done}, 128'h0);
    @(negedge clk);
    check("done_after_c18", {127'h0, done}, 128'h1);
    check("dword_zero_in_done", {96'h0, dword_out}, 128'h0);
  endtask

  // Single readout pulse of start_read_n in DONE.
  task automatic do_read(input logic [127:0] ct);
    start_read_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_read_n = 1'b1;
      check($sformatf("read_word%0d", k), {96'h0, dword_out}, {96'h0, ct[127 - 32*k -: 32]});
    end
    @(negedge clk);
    check("read_end_zero", {96'h0, dword_out}, 128'h0);
`ifdef AES_ZEROIZE_EN
    check("read_end_done", {127'h0, done}, 128'h0);
`else
    check("read_end_done", {127'h0, done}, 128'h1);
`endif
  endtask

  initial begin
    vecs[0] = '{pt:  128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{pt:  128'h0,
                key: 128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[2] = '{pt:  128'h3243f6a8885a308d313198a2e0370734,
                key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};

    reset_n      = 1'b0;
    start_n      = 1'b1;
    start_read_n = 1'b1;
    dword_in     = '0;
    repeat (2) @(negedge clk);
    check("reset_done", {127'h0, done}, 128'h0);
    check("reset_dword", {96'h0, dword_out}, 128'h0);

    // Start is driven on the very first edge after reset release.
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_load(vecs[i].pt, vecs[i].key, 1'b0);
      run_wait();
      do_read(vecs[i].ct);
    end

    // start_n and start_read_n both low in DONE: load wins, no readout.
    do_load(vecs[0].pt, vecs[0].key, 1'b0);
    run_wait();
    do_load(vecs[1].pt, vecs[1].key, 1'b1);
    run_wait();
    do_read(vecs[1].ct);

`ifdef AES_ZEROIZE_EN
    // After a zeroizing readout the block sits in IDLE; read requests do nothing.
    start_read_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("zeroized_dword", {96'h0, dword_out}, 128'h0);
      check("zeroized_done", {127'h0, done}, 128'h0);
    end
    start_read_n = 1'b1;
`else
    // start_read_n held low: two back-to-back readouts with a zero word between.
    start_read_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("held_read1_word%0d", k), {96'h0, dword_out}, {96'h0, vecs[1].ct[127 - 32*k -: 32]});
    end
    @(negedge clk);
    check("held_between_zero", {96'h0, dword_out}, 128'h0);
    check("held_between_done", {127'h0, done}, 128'h1);
    @(negedge clk);
    check("held_read2_word0", {96'h0, dword_out}, {96'h0, vecs[1].ct[127:96]});
    start_read_n = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("held_read2_word%0d", k), {96'h0, dword_out}, {96'h0, vecs[1].ct[127 - 32*k -: 32]});
    end
    @(negedge clk);
    check("held_read2_end_zero", {96'h0, dword_out}, 128'h0);
`endif

    // Reset pulse at C12, then a fresh load straight after release.
    do_load(vecs[2].pt, vecs[2].key, 1'b0);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_c12_done", {127'h0, done}, 128'h0);
    check("rst_c12_dword", {96'h0, dword_out}, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    do_load(vecs[0].pt, vecs[0].key, 1'b0);
    run_wait();

    // Reset in the middle of a readout clears the output at once.
    start_read_n = 1'b0;
    @(negedge clk);
    start_read_n = 1'b1;
    check("midread_word0", {96'h0, dword_out}, {96'h0, vecs[0].ct[127:96]});
    @(negedge clk);
    check("midread_word1", {96'h0, dword_out}, {96'h0, vecs[0].ct[95:64]});
    #1 reset_n = 1'b0;
    #1;
    check("rst_read_dword", {96'h0, dword_out}, 128'h0);
    check("rst_read_done", {127'h0, done}, 128'h0);
    @(negedge clk);
    check("rst_hold_dword", {96'h0, dword_out}, 128'h0);
    reset_n = 1'b1;
    do_load(vecs[2].pt, vecs[2].key, 1'b0);
    run_wait();
    do_read(vecs[2].ct);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
